// File: rtl/hazard_unit.sv
// Pipeline hazard unit: load-use stall, taken-branch flush and, when built with
// HAZ_MDU_STALL_EN, a multiply/divide occupancy tracker that stalls HI/LO users.
`ifndef RF_REG_W
`define RF_REG_W 5
`endif

module hazard_unit #(
    parameter int MDU_LAT = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [`RF_REG_W-1:0] iIF_ID_ppRs,
    input  logic [`RF_REG_W-1:0] iIF_ID_ppRt,
    input  logic [`RF_REG_W-1:0] iID_EX_ppRt,
    input  logic                 iID_EX_ppMemRd,
    input  logic                 iBranchTaken,
    input  logic                 iMduStart,
    input  logic                 iUsesHiLo,
    output logic                 oPCWrEn,
    output logic                 oIF_ID_WrEn,
    output logic                 oIF_ID_Flush,
    output logic                 oID_EX_Bubble,
    output logic                 oMduBusy
);

    logic w_load_use;
    logic w_stall;

    // r0 is hard-wired zero, so a load targeting it never creates a dependency
    assign w_load_use = iID_EX_ppMemRd && (iID_EX_ppRt != '0) &&
                        ((iID_EX_ppRt == iIF_ID_ppRs) || (iID_EX_ppRt == iIF_ID_ppRt));

`ifdef HAZ_MDU_STALL_EN
    typedef enum logic {
        S_IDLE,
        S_MDU_BUSY
    } state_t;

    localparam logic [5:0] LAT_M1 = 6'(MDU_LAT - 1);

    state_t     r_state;
    state_t     w_state_next;
    logic [5:0] r_mdu_cnt;
    logic [5:0] w_mdu_cnt_next;
    logic       w_hilo_haz;
    logic       w_accept;

    assign w_hilo_haz = (r_state == S_MDU_BUSY) && (iUsesHiLo || iMduStart);
    assign w_stall    = w_load_use || w_hilo_haz;
    assign w_accept   = (r_state == S_IDLE) && iMduStart && !w_stall && !iBranchTaken;
    assign oMduBusy   = (r_state == S_MDU_BUSY);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_mdu_cnt <= '0;
        end else begin
            r_state   <= w_state_next;
            r_mdu_cnt <= w_mdu_cnt_next;
        end
    end

    // The count runs down unconditionally once busy; stalls and flushes do not pause the unit
    always_comb begin
        w_state_next   = r_state;
        w_mdu_cnt_next = r_mdu_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_next   = S_MDU_BUSY;
                    w_mdu_cnt_next = LAT_M1;
                end
            end
            S_MDU_BUSY: begin
                if (r_mdu_cnt == '0) begin
                    w_state_next = S_IDLE;
                end else begin
                    w_mdu_cnt_next = r_mdu_cnt - 6'd1;
                end
            end
            default: begin
                w_state_next   = S_IDLE;
                w_mdu_cnt_next = '0;
            end
        endcase
    end
`else
    logic w_unused;

    assign w_unused = ^{clk, rst, iMduStart, iUsesHiLo};
    assign w_stall  = w_load_use;
    assign oMduBusy = 1'b0;
`endif

    // A taken branch squashes both younger instructions, which also kills any stall
    always_comb begin
        oPCWrEn       = 1'b1;
        oIF_ID_WrEn   = 1'b1;
        oIF_ID_Flush  = 1'b0;
        oID_EX_Bubble = 1'b0;
        if (iBranchTaken) begin
            oIF_ID_Flush  = 1'b1;
            oID_EX_Bubble = 1'b1;
        end else if (w_stall) begin
            oPCWrEn       = 1'b0;
            oIF_ID_WrEn   = 1'b0;
            oID_EX_Bubble = 1'b1;
        end
    end

endmodule
